// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage, the instruction memory and the decode stage.
// master: fetch stage side; slave: memory / pipeline-control / decode side.
interface fetch_stage_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH = 21
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_data;
    logic                  stall;
    logic                  flush;
    logic                  redirect_valid;
    logic [PC_WIDTH-1:0]   redirect_pc;
    logic                  ir_valid;
    logic [DATA_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0] imm;
    logic [PC_WIDTH-1:0]   ir_pc;
    logic [PC_WIDTH-1:0]   ir_next_pc;

    modport master (
        output imem_addr, ir_valid, ir, imm, ir_pc, ir_next_pc,
        input  imem_data, stall, flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_addr, ir_valid, ir, imm, ir_pc, ir_next_pc,
        output imem_data, stall, flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// loads the IF/ID register, assembling opcode+immediate two-word instructions.
module fetch_stage #(
    parameter int unsigned           DATA_WIDTH   = 16,
    parameter int unsigned           PC_WIDTH     = 32,
    parameter int unsigned           ADDR_WIDTH   = 21,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
    parameter logic [DATA_WIDTH-1:0] LONG_MASK    = 16'hC000,
    parameter logic [DATA_WIDTH-1:0] LONG_MATCH   = 16'hC000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    localparam logic [0:0] FETCH_OP  = 1'b0;
    localparam logic [0:0] FETCH_IMM = 1'b1;

    logic [0:0]            state_q,      state_d;
    logic [PC_WIDTH-1:0]   pc_q,         pc_d;
    logic [DATA_WIDTH-1:0] op_hold_q,    op_hold_d;
    logic [PC_WIDTH-1:0]   op_pc_q,      op_pc_d;
    logic                  ir_valid_q,   ir_valid_d;
    logic [DATA_WIDTH-1:0] ir_q,         ir_d;
    logic [DATA_WIDTH-1:0] imm_q,        imm_d;
    logic [PC_WIDTH-1:0]   ir_pc_q,      ir_pc_d;
    logic [PC_WIDTH-1:0]   ir_next_pc_q, ir_next_pc_d;

    logic [PC_WIDTH-1:0]   pc_inc;
    logic                  is_long;

    assign pc_inc  = pc_q + PC_WIDTH'(1);
    assign is_long = (bus.imem_data & LONG_MASK) == LONG_MATCH;

    assign bus.imem_addr  = pc_q[ADDR_WIDTH-1:0];
    assign bus.ir_valid   = ir_valid_q;
    assign bus.ir         = ir_q;
    assign bus.imm        = imm_q;
    assign bus.ir_pc      = ir_pc_q;
    assign bus.ir_next_pc = ir_next_pc_q;

    // Next-state: redirect beats flush beats stall beats normal fetch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        op_hold_d    = op_hold_q;
        op_pc_d      = op_pc_q;
        ir_valid_d   = ir_valid_q;
        ir_d         = ir_q;
        imm_d        = imm_q;
        ir_pc_d      = ir_pc_q;
        ir_next_pc_d = ir_next_pc_q;

        if (bus.redirect_valid) begin
            pc_d       = bus.redirect_pc;
            state_d    = FETCH_OP;
            ir_valid_d = 1'b0;
        end else if (bus.flush) begin
            ir_valid_d = 1'b0;
        end else if (!bus.stall) begin
            pc_d = pc_inc;
            case (state_q)
                FETCH_OP: begin
                    if (is_long) begin
                        op_hold_d  = bus.imem_data;
                        op_pc_d    = pc_q;
                        ir_valid_d = 1'b0;
                        state_d    = FETCH_IMM;
                    end else begin
                        ir_d         = bus.imem_data;
                        imm_d        = '0;
                        ir_pc_d      = pc_q;
                        ir_next_pc_d = pc_inc;
                        ir_valid_d   = 1'b1;
                    end
                end
                default: begin
                    ir_d         = op_hold_q;
                    imm_d        = bus.imem_data;
                    ir_pc_d      = op_pc_q;
                    ir_next_pc_d = pc_inc;
                    ir_valid_d   = 1'b1;
                    state_d      = FETCH_OP;
                end
            endcase
        end
    end

    // State and IF/ID register, asynchronously reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FETCH_OP;
            pc_q         <= RESET_VECTOR;
            op_hold_q    <= '0;
            op_pc_q      <= '0;
            ir_valid_q   <= 1'b0;
            ir_q         <= '0;
            imm_q        <= '0;
            ir_pc_q      <= '0;
            ir_next_pc_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            op_hold_q    <= op_hold_d;
            op_pc_q      <= op_pc_d;
            ir_valid_q   <= ir_valid_d;
            ir_q         <= ir_d;
            imm_q        <= imm_d;
            ir_pc_q      <= ir_pc_d;
            ir_next_pc_q <= ir_next_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a 32-bit-PC instance and an 8-bit-PC
// instance share one instruction memory and one stimulus stream; both are
// compared every cycle against a word-assembly reference model.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if #(.DATA_WIDTH(16), .PC_WIDTH(32), .ADDR_WIDTH(21)) bus_a ();
    fetch_stage_if #(.DATA_WIDTH(16), .PC_WIDTH(8),  .ADDR_WIDTH(8))  bus_b ();

    fetch_stage #(
        .DATA_WIDTH(16), .PC_WIDTH(32), .ADDR_WIDTH(21),
        .RESET_VECTOR(32'h10), .LONG_MASK(16'hC000), .LONG_MATCH(16'hC000)
    ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

    fetch_stage #(
        .DATA_WIDTH(16), .PC_WIDTH(8), .ADDR_WIDTH(8),
        .RESET_VECTOR(8'hFF), .LONG_MASK(16'hC000), .LONG_MATCH(16'hC000)
    ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    logic [15:0] mem [256];
    assign bus_a.imem_data = mem[bus_a.imem_addr[7:0]];
    assign bus_b.imem_data = mem[bus_b.imem_addr[7:0]];

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: words are consumed one per productive cycle from pc;
    // an instruction is issued once all of its words have been collected.
    logic [31:0] m_mask [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] m_rv   [2] = '{32'h10, 32'hFF};
    logic [31:0] m_pc [2];
    bit          m_have_op [2];
    logic [15:0] m_op_w [2];
    logic [31:0] m_op_pc [2];
    bit          m_valid [2];
    logic [15:0] m_ir [2];
    logic [15:0] m_imm [2];
    logic [31:0] m_irpc [2];
    logic [31:0] m_nxt [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = m_rv[k];
            m_have_op[k] = 0; m_op_w[k] = '0; m_op_pc[k] = '0;
            m_valid[k] = 0; m_ir[k] = '0; m_imm[k] = '0; m_irpc[k] = '0; m_nxt[k] = '0;
        end
    endtask

    task automatic model_step(input int k, input bit st, input bit fl, input bit rv, input logic [31:0] rpc);
        logic [15:0] w;
        logic [31:0] after;
        if (rv) begin
            m_pc[k] = rpc & m_mask[k];
            m_have_op[k] = 0;
            m_valid[k] = 0;
        end else if (fl) begin
            m_valid[k] = 0;
        end else if (!st) begin
            w = mem[m_pc[k][7:0]];
            after = (m_pc[k] + 32'd1) & m_mask[k];
            if (m_have_op[k]) begin
                m_ir[k] = m_op_w[k]; m_imm[k] = w; m_irpc[k] = m_op_pc[k];
                m_nxt[k] = after; m_valid[k] = 1; m_have_op[k] = 0;
            end else if (w[15:14] == 2'b11) begin
                m_op_w[k] = w; m_op_pc[k] = m_pc[k]; m_have_op[k] = 1; m_valid[k] = 0;
            end else begin
                m_ir[k] = w; m_imm[k] = '0; m_irpc[k] = m_pc[k];
                m_nxt[k] = after; m_valid[k] = 1;
            end
            m_pc[k] = after;
        end
    endtask

    task automatic cmp_all();
        check("a_valid", 64'(bus_a.ir_valid),   64'(m_valid[0]));
        check("a_addr",  64'(bus_a.imem_addr),  64'(m_pc[0][20:0]));
        check("a_ir",    64'(bus_a.ir),         64'(m_ir[0]));
        check("a_imm",   64'(bus_a.imm),        64'(m_imm[0]));
        check("a_irpc",  64'(bus_a.ir_pc),      64'(m_irpc[0]));
        check("a_nxt",   64'(bus_a.ir_next_pc), 64'(m_nxt[0]));
        check("b_valid", 64'(bus_b.ir_valid),   64'(m_valid[1]));
        check("b_addr",  64'(bus_b.imem_addr),  64'(m_pc[1][7:0]));
        check("b_ir",    64'(bus_b.ir),         64'(m_ir[1]));
        check("b_imm",   64'(bus_b.imm),        64'(m_imm[1]));
        check("b_irpc",  64'(bus_b.ir_pc),      64'(m_irpc[1][7:0]));
        check("b_nxt",   64'(bus_b.ir_next_pc), 64'(m_nxt[1][7:0]));
    endtask

    // Apply one cycle of control inputs to both instances, clock, then compare.
    task automatic cycle(input bit st, input bit fl, input bit rv, input logic [31:0] rpc);
        bus_a.stall = st; bus_a.flush = fl; bus_a.redirect_valid = rv; bus_a.redirect_pc = rpc;
        bus_b.stall = st; bus_b.flush = fl; bus_b.redirect_valid = rv; bus_b.redirect_pc = rpc[7:0];
        @(posedge clk);
        model_step(0, st, fl, rv, rpc);
        model_step(1, st, fl, rv, rpc);
        #1;
        cmp_all();
    endtask

    initial begin
        logic [15:0] w;
        logic [31:0] rpc;
        bit st, fl, rv;

        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if ($urandom_range(2) == 0) w[15:14] = 2'b11;
            else w[15] = 1'b0;
            mem[i] = w;
        end
        mem[8'h00] = 16'hC005; mem[8'h01] = 16'hBEEF; mem[8'h02] = 16'h0007;
        mem[8'h05] = 16'h0055;
        mem[8'h10] = 16'h1234; mem[8'h11] = 16'h0001; mem[8'h12] = 16'h2000;
        mem[8'h40] = 16'h0042; mem[8'hFF] = 16'h0123;

        bus_a.stall = 0; bus_a.flush = 0; bus_a.redirect_valid = 0; bus_a.redirect_pc = '0;
        bus_b.stall = 0; bus_b.flush = 0; bus_b.redirect_valid = 0; bus_b.redirect_pc = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cmp_all();
        check("rst_addr_a", 64'(bus_a.imem_addr), 64'h10);
        check("rst_addr_b", 64'(bus_b.imem_addr), 64'hFF);

        // one-word stream from the reset vector; 8-bit instance wraps
        cycle(0, 0, 0, 0);
        check("seq_ir0", 64'(bus_a.ir), 64'h1234);
        check("wrap_nxt", 64'(bus_b.ir_next_pc), 64'h00);
        check("wrap_addr", 64'(bus_b.imem_addr), 64'h00);
        cycle(0, 0, 0, 0);
        check("seq_ir1", 64'(bus_a.ir), 64'h0001);
        cycle(0, 0, 0, 0);
        check("seq_ir2", 64'(bus_a.ir), 64'h2000);
        check("seq_nxt2", 64'(bus_a.ir_next_pc), 64'h13);

        // two-word instruction with a 3-cycle stall in FETCH_IMM
        cycle(0, 0, 1, 32'h0);
        cycle(0, 0, 0, 0);
        check("tw_bubble", 64'(bus_a.ir_valid), 64'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0);
            check("stall_addr", 64'(bus_a.imem_addr), 64'h1);
        end
        cycle(0, 0, 0, 0);
        check("tw_ir", 64'(bus_a.ir), 64'hC005);
        check("tw_imm", 64'(bus_a.imm), 64'hBEEF);
        check("tw_nxt", 64'(bus_a.ir_next_pc), 64'h2);
        cycle(0, 0, 0, 0);
        check("tw_after", 64'(bus_a.imm), 64'h0);

        // redirect in FETCH_IMM alongside stall and flush
        cycle(0, 0, 1, 32'h0);
        cycle(0, 0, 0, 0);
        cycle(1, 1, 1, 32'h40);
        check("rd_valid", 64'(bus_a.ir_valid), 64'h0);
        check("rd_addr", 64'(bus_a.imem_addr), 64'h40);
        cycle(0, 0, 0, 0);
        check("rd_ir", 64'(bus_a.ir), 64'h0042);

        // flush alone for two cycles at pc 5
        cycle(0, 0, 1, 32'h5);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 0, 0);
            check("fl_addr", 64'(bus_a.imem_addr), 64'h5);
        end
        cycle(0, 0, 0, 0);
        check("fl_ir", 64'(bus_a.ir), 64'h0055);

        // asynchronous reset in the middle of a two-word fetch
        cycle(0, 0, 1, 32'h0);
        cycle(0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        cmp_all();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cycle(0, 0, 0, 0);
        check("post_rst_ir", 64'(bus_a.ir), 64'h1234);

        // randomized control traffic
        for (int n = 0; n < 600; n++) begin
            st = ($urandom_range(99) < 20);
            fl = ($urandom_range(99) < 10);
            rv = ($urandom_range(99) < 8);
            case ($urandom_range(7))
                0: rpc = 32'hFFFF_FFFF - 32'($urandom_range(2));
                1: rpc = $urandom;
                default: rpc = 32'($urandom_range(255));
            endcase
            cycle(st, fl, rv, rpc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Parametrised instruction-fetch stage that owns the program counter, drives the instruction-memory address and loads the IF/ID register. It generalises the PC / incrementor / IR path to configurable widths and adds stall, flush, branch redirect and two-word (opcode + immediate) instruction assembly. It sits between the instruction memory and the decode/control unit of the five-stage pipeline.

## Interface
- DATA_WIDTH, 16, instruction word width
- PC_WIDTH, 32, program counter width
- ADDR_WIDTH, 21, instruction-memory address width (ADDR_WIDTH ≤ PC_WIDTH)
- RESET_VECTOR, 0, PC value loaded on reset
- LONG_MASK, 16'hC000, opcode bits examined for two-word detection
- LONG_MATCH, 16'hC000, word is two-word when (word & LONG_MASK) == LONG_MATCH

- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- imem_addr  out  ADDR_WIDTH  = pc[ADDR_WIDTH-1:0], combinational
- imem_data  in  DATA_WIDTH  word at imem_addr, valid same cycle
- stall  in  1  hold PC, FSM and IF/ID
- flush  in  1  insert bubble into IF/ID
- redirect_valid  in  1  load new PC (branch/jump/call/ret)
- redirect_pc  in  PC_WIDTH  target PC
- ir_valid  out  1  IF/ID holds a real instruction
- ir  out  DATA_WIDTH  opcode word
- imm  out  DATA_WIDTH  immediate word (0 for one-word instructions)
- ir_pc  out  PC_WIDTH  address of opcode word
- ir_next_pc  out  PC_WIDTH  address following the instruction (return address)

## Operation
- Internal state: pc, FSM {FETCH_OP, FETCH_IMM}, op_hold, op_pc; all outputs registered except imem_addr.
- Per-edge priority: reset > redirect_valid > flush > stall > normal.
- FETCH_OP, normal: if imem_data is one-word → ir←imem_data, imm←0, ir_pc←pc, ir_next_pc←pc+1, ir_valid←1, pc←pc+1. If two-word → op_hold←imem_data, op_pc←pc, pc←pc+1, ir_valid←0, FSM→FETCH_IMM.
- FETCH_IMM, normal: ir←op_hold, imm←imem_data, ir_pc←op_pc, ir_next_pc←pc+1, ir_valid←1, pc←pc+1, FSM→FETCH_OP.
- redirect_valid: pc←redirect_pc, FSM→FETCH_OP (partial two-word discarded), ir_valid←0; overrides flush and stall.
- flush (no redirect): ir_valid←0; pc, FSM, op_hold hold (word not consumed).
- stall (no redirect/flush): every register holds, including ir_valid.
- Arithmetic: pc+1 modulo 2^PC_WIDTH; 2^PC_WIDTH−1 wraps to 0; imem_addr is truncation of pc.
- When ir_valid=0, ir/imm/ir_pc/ir_next_pc keep last value; consumers ignore them.

## Timing
- Reset (async assert): pc=RESET_VECTOR, FSM=FETCH_OP, ir_valid=0, ir=0, imm=0, ir_pc=0, ir_next_pc=0, op_hold=0, op_pc=0; imem_addr=RESET_VECTOR[ADDR_WIDTH-1:0] immediately.
- Reset mid two-word fetch: partial opcode dropped, restart at RESET_VECTOR.
- First edge after reset release fetches RESET_VECTOR.
- One-word instruction: visible on ir one edge after its address is on imem_addr; throughput 1/cycle.
- Two-word instruction: visible one edge after immediate address; one bubble cycle (ir_valid=0) between it and the previous instruction.
- Redirect asserted on edge N: imem_addr=redirect_pc after N; first target instruction on ir after N+1 (one-word) or N+2 (two-word).
- Stall held k cycles extends the current state by exactly k cycles; no word skipped or duplicated.

## Test plan
- Reset, RESET_VECTOR=0x10, memory 0x10..0x12 = 0x1234,0x0001,0x2000 one-word → ir 0x1234/0x0001/0x2000 on edges 1-3, ir_pc 0x10/0x11/0x12, ir_next_pc 0x11/0x12/0x13.
- Two-word: mem[0]=0xC005, mem[1]=0xBEEF, mem[2]=0x0007 → edge1 ir_valid=0; edge2 ir=0xC005, imm=0xBEEF, ir_pc=0, ir_next_pc=2; edge3 ir=0x0007, imm=0.
- Stall 3 cycles during FETCH_IMM of above → outputs frozen, then ir=0xC005/imm=0xBEEF after release; imem_addr stays 1 throughout stall.
- Redirect to 0x40 in FETCH_IMM with simultaneous stall and flush → op_hold discarded, ir_valid=0 next edge, imem_addr=0x40, mem[0x40] appears on ir one edge later.
- Flush alone for 2 cycles at pc=5 → ir_valid=0 twice, pc stays 5, then mem[5] issued.
- PC_WIDTH=8, pc=0xFF one-word → ir_next_pc=0x00, next fetch address 0x00; async reset mid-cycle during FETCH_IMM → all outputs to reset values before next edge.
